fib_stream_gen: RTL

Parametrised, restartable generator for Fibonacci-type sequences (t[n] = t[n-1] + t[n-2]) with programmable seeds and term count. Output is a valid/ready stream with last-term marking and overflow termination. It replaces the free-running fixed-seed generator and feeds downstream stream consumers and test-pattern sources. Seeds 1,1 give Fibonacci; seeds 2,1 give Lucas.

---
 rtl/fib_stream_gen_pkg.sv | 12 +
 rtl/fib_stream_gen_if.sv | 29 ++
 rtl/fib_stream_gen.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fib_stream_gen_pkg.sv
// Shared types and default widths for the Fibonacci-type stream generator.
package fib_stream_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int CNT_WIDTH  = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/fib_stream_gen_if.sv
// Valid/ready term stream carrying data, index and last-term marking.
interface fib_stream_gen_if #(
    parameter int DATA_WIDTH = fib_stream_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = fib_stream_pkg::CNT_WIDTH
);

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0]  out_index;
    logic                  out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/fib_stream_gen.sv
// Restartable t[n] = t[n-1] + t[n-2] generator with programmable seeds and
// term count; the sequence stops on the last term that fits in DATA_WIDTH.
module fib_stream_gen #(
    parameter int DATA_WIDTH = fib_stream_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = fib_stream_pkg::CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed0,
    input  logic [DATA_WIDTH-1:0] seed1,
    input  logic [CNT_WIDTH-1:0]  num_terms,
    output logic                  busy,
    output logic                  overflow,
    output logic                  done,
    fib_stream_gen_if.master      out_if
);

    import fib_stream_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    state_t                state_r, state_s;
    logic [DATA_WIDTH-1:0] a_r, a_s;
    logic [DATA_WIDTH-1:0] b_r, b_s;
    logic                  b_ok_r, b_ok_s;
    logic [CNT_WIDTH-1:0]  cnt_r, cnt_s;
    logic [CNT_WIDTH-1:0]  index_r, index_s;
    logic                  overflow_r, overflow_s;
    logic                  done_r, done_s;

    logic [DATA_WIDTH:0]   sum_s;
    logic [CNT_WIDTH-1:0]  cnt_m1_s;
    logic                  last_s;

    // b_ok_r says whether b (the next term) fits, so last also covers the overflow stop.
    assign sum_s    = {1'b0, a_r} + {1'b0, b_r};
    assign cnt_m1_s = cnt_r - CNT_ONE;
    assign last_s   = (index_r == cnt_m1_s) || !b_ok_r;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            a_r        <= {DATA_WIDTH{1'b0}};
            b_r        <= {DATA_WIDTH{1'b0}};
            b_ok_r     <= 1'b0;
            cnt_r      <= CNT_ZERO;
            index_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            a_r        <= a_s;
            b_r        <= b_s;
            b_ok_r     <= b_ok_s;
            cnt_r      <= cnt_s;
            index_r    <= index_s;
            overflow_r <= overflow_s;
            done_r     <= done_s;
        end
    end

    // Next-state logic: start handling in IDLE, term advance on handshake in RUN.
    always_comb begin
        state_s    = state_r;
        a_s        = a_r;
        b_s        = b_r;
        b_ok_s     = b_ok_r;
        cnt_s      = cnt_r;
        index_s    = index_r;
        overflow_s = overflow_r;
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && (num_terms != CNT_ZERO)) begin
                    a_s        = seed0;
                    b_s        = seed1;
                    cnt_s      = num_terms;
                    index_s    = CNT_ZERO;
                    b_ok_s     = 1'b1;
                    overflow_s = 1'b0;
                    state_s    = RUN;
                end else if (start) begin
                    overflow_s = 1'b0;
                    done_s     = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (out_if.out_ready && last_s) begin
                    state_s    = IDLE;
                    done_s     = 1'b1;
                    overflow_s = !b_ok_r && (index_r < cnt_m1_s);
                end else if (out_if.out_ready) begin
                    a_s     = b_r;
                    b_s     = sum_s[DATA_WIDTH-1:0];
                    b_ok_s  = b_ok_r && !sum_s[DATA_WIDTH];
                    index_s = index_r + CNT_ONE;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign busy             = (state_r == RUN);
    assign overflow         = overflow_r;
    assign done             = done_r;
    assign out_if.out_valid = (state_r == RUN);
    assign out_if.out_data  = a_r;
    assign out_if.out_index = index_r;
    assign out_if.out_last  = (state_r == RUN) && last_s;

endmodule
